// File: rtl/ps2_mouse_tracker_if.sv
// Pin-side and game-side signal bundle of the PS/2 mouse tracker.
// master drives the raw PS/2 pins; slave is the tracker itself.
interface ps2_mouse_tracker_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        left_btn;
    logic        right_btn;
    logic        packet_valid;

    modport master (
        output ps2_clk, ps2_data,
        input  x_pos, y_pos, left_btn, right_btn, packet_valid
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output x_pos, y_pos, left_btn, right_btn, packet_valid
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: frames device-to-host bytes, assembles 3-byte movement packets and
// integrates clamped cursor coordinates. Define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_mouse_tracker #(
    parameter int X_MAX          = 799,
    parameter int Y_MAX          = 599,
    parameter int X_INIT         = 400,
    parameter int Y_INIT         = 300,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_mouse_tracker_if.slave mouse
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [13:0] X_MAX_S = 14'(X_MAX);
    localparam logic signed [13:0] Y_MAX_S = 14'(Y_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

    logic [1:0]     clk_sync_q;
    logic [1:0]     data_sync_q;
    logic           filt_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           fall_s;
    logic           data_s;

    state_t         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic [1:0]     byte_idx_q;
    logic [5:0]     hdr_q;      // {y_ovf, x_ovf, y_sign, x_sign, right, left}
    logic [7:0]     byte1_q;
    logic [TCW-1:0] tmo_q;

    logic [11:0]    x_q;
    logic [11:0]    y_q;
    logic           left_q;
    logic           right_q;
    logic           valid_q;

    logic signed [13:0] dx_s;
    logic signed [13:0] dy_s;
    logic signed [13:0] x_sum_s;
    logic signed [13:0] y_sum_s;
    logic [11:0]        x_new_s;
    logic [11:0]        y_new_s;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit_q;

    function automatic logic odd_weight(input logic [8:0] v);
        return ^v;
    endfunction
`endif

    // The filtered clock falls on the cycle the FILTER_LEN-th consecutive low sample arrives.
    assign fall_s = filt_q && !clk_sync_q[1] && (filt_cnt_q == FCW'(FILTER_LEN - 1));
    assign data_s = data_sync_q[1];

    // Pin synchronizers and ps2_clk glitch filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], mouse.ps2_clk};
            data_sync_q <= {data_sync_q[0], mouse.ps2_data};
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // Saturating position update; byte 2 is still in the shift register when it is consumed.
    always_comb begin
        dx_s    = hdr_q[4] ? 14'sd0 : {{5{hdr_q[2]}}, hdr_q[2], byte1_q};
        dy_s    = hdr_q[5] ? 14'sd0 : {{5{hdr_q[3]}}, hdr_q[3], shift_q};
        x_sum_s = $signed({2'b00, x_q}) + dx_s;
        y_sum_s = $signed({2'b00, y_q}) - dy_s;
        if (x_sum_s < 14'sd0) begin
            x_new_s = 12'd0;
        end else if (x_sum_s > X_MAX_S) begin
            x_new_s = X_MAX_S[11:0];
        end else begin
            x_new_s = x_sum_s[11:0];
        end
        if (y_sum_s < 14'sd0) begin
            y_new_s = 12'd0;
        end else if (y_sum_s > Y_MAX_S) begin
            y_new_s = Y_MAX_S[11:0];
        end else begin
            y_new_s = y_sum_s[11:0];
        end
    end

    // Frame FSM, timeout supervisor, packet assembly and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            byte_idx_q <= 2'd0;
            hdr_q      <= 6'd0;
            byte1_q    <= 8'd0;
            tmo_q      <= '0;
            x_q        <= 12'(X_INIT);
            y_q        <= 12'(Y_INIT);
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            valid_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;

            if (fall_s) begin
                tmo_q <= '0;
            end else if (state_q != IDLE || byte_idx_q != 2'd0) begin
                if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_q      <= '0;
                    state_q    <= IDLE;
                    byte_idx_q <= 2'd0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end

            if (fall_s) begin
                case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit_q <= data_s;
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        // A missing stop bit drops only this byte; the packet position is kept.
                        if (data_s) begin
`ifdef PS2_PARITY_CHECK_EN
                            if (!odd_weight({shift_q, par_bit_q})) begin
                                byte_idx_q <= 2'd0;
                            end else begin
`else
                            begin
`endif
                                case (byte_idx_q)
                                    2'd0: begin
                                        if (shift_q[3]) begin
                                            hdr_q      <= {shift_q[7:4], shift_q[1:0]};
                                            byte_idx_q <= 2'd1;
                                        end
                                    end
                                    2'd1: begin
                                        byte1_q    <= shift_q;
                                        byte_idx_q <= 2'd2;
                                    end
                                    2'd2: begin
                                        x_q        <= x_new_s;
                                        y_q        <= y_new_s;
                                        left_q     <= hdr_q[0];
                                        right_q    <= hdr_q[1];
                                        valid_q    <= 1'b1;
                                        byte_idx_q <= 2'd0;
                                    end
                                    default: byte_idx_q <= 2'd0;
                                endcase
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mouse.x_pos        = x_q;
    assign mouse.y_pos        = y_q;
    assign mouse.left_btn     = left_q;
    assign mouse.right_btn    = right_q;
    assign mouse.packet_valid = valid_q;
endmodule
